// File: rtl/sdram_ctrl_pkg.sv
// Shared command encodings and init-sequencer state type for the SDRAM controller.
package sdram_ctrl_pkg;

  localparam logic [1:0] CMD_NOP    = 2'b00;
  localparam logic [1:0] CMD_READA  = 2'b01;
  localparam logic [1:0] CMD_WRITEA = 2'b10;

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_PRE,
    ST_REF,
    ST_LMR,
    ST_DONE
  } init_state_e;

endpackage

// File: rtl/sdram_init_refresh_ctrl_if.sv
// Host command bus into the SDRAM controller and its registered decode back out.
interface sdram_init_refresh_ctrl_if #(
  parameter int ASIZE = 23
) ();

  logic [1:0]       CMD;
  logic [ASIZE-1:0] ADDR;
  logic             CM_ACK;
  logic             NOP;
  logic             READA;
  logic             WRITEA;
  logic [ASIZE-1:0] SADDR;
  logic             CMD_ACK;

  modport master (
    output CMD, ADDR, CM_ACK,
    input  NOP, READA, WRITEA, SADDR, CMD_ACK
  );

  modport slave (
    input  CMD, ADDR, CM_ACK,
    output NOP, READA, WRITEA, SADDR, CMD_ACK
  );

endinterface

// File: rtl/sdram_refresh_scheduler.sv
// Free-running refresh interval timer plus saturating count of refreshes still owed.
module sdram_refresh_scheduler #(
  parameter int REF_PER      = 1024,
  parameter int MAX_REF_DEBT = 8
) (
  input  logic                              CLK,
  input  logic                              RESET_N,
  input  logic                              enable,
  input  logic                              clear,
  input  logic                              REF_ACK,
  output logic [$clog2(MAX_REF_DEBT+1)-1:0] REF_DEBT,
  output logic                              REF_REQ,
  output logic                              REF_URGENT
);

  localparam int TMW = $clog2(REF_PER);
  localparam int DW  = $clog2(MAX_REF_DEBT + 1);

  logic [TMW-1:0] timer_q;
  logic [DW-1:0]  debt_d;
  logic           expire;
  logic           ack;

  assign expire = enable && (timer_q == '0);
  // an acknowledge with nothing owed is dropped rather than cancelling an expiry
  assign ack    = enable && REF_ACK && (REF_DEBT != '0);

  always_comb begin
    debt_d = REF_DEBT;
    if (expire && !ack) begin
      if (REF_DEBT != DW'(MAX_REF_DEBT)) debt_d = REF_DEBT + 1'b1;
    end else if (ack && !expire) begin
      debt_d = REF_DEBT - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      timer_q    <= TMW'(REF_PER - 1);
      REF_DEBT   <= '0;
      REF_REQ    <= 1'b0;
      REF_URGENT <= 1'b0;
    end else if (clear) begin
      timer_q    <= TMW'(REF_PER - 1);
      REF_DEBT   <= '0;
      REF_REQ    <= 1'b0;
      REF_URGENT <= 1'b0;
    end else begin
      if (!enable || timer_q == '0) timer_q <= TMW'(REF_PER - 1);
      else                          timer_q <= timer_q - 1'b1;
      REF_DEBT   <= debt_d;
      REF_REQ    <= (debt_d != '0);
      REF_URGENT <= (debt_d >= DW'(MAX_REF_DEBT - 1));
    end
  end

endmodule

// File: rtl/sdram_init_refresh_ctrl.sv
// SDRAM power-up init sequencer, registered command decode and refresh bookkeeping.
// state | meaning
// WAIT  | power-up wait, INIT_REQ high for the first INIT_PER cycles
// PRE   | precharge-all issued, gap to first refresh
// REF   | INIT_REF_CNT auto-refreshes, CMD_GAP apart
// LMR   | load mode register (one cycle)
// DONE  | init complete, normal operation
module sdram_init_refresh_ctrl
  import sdram_ctrl_pkg::*;
#(
  parameter int ASIZE        = 23,
  parameter int INIT_PER     = 24000,
  parameter int REF_PER      = 1024,
  parameter int INIT_REF_CNT = 8,
  parameter int CMD_GAP      = 20,
  parameter int MAX_REF_DEBT = 8
) (
  input  logic                              CLK,
  input  logic                              RESET_N,
  sdram_init_refresh_ctrl_if.slave          bus,
  input  logic                              REF_ACK,
  input  logic                              INIT_START,
  output logic                              PRECHARGE,
  output logic                              REFRESH,
  output logic                              LOAD_MODE,
  output logic                              INIT_REQ,
  output logic                              REF_REQ,
  output logic                              REF_URGENT,
  output logic [$clog2(MAX_REF_DEBT+1)-1:0] REF_DEBT,
  output logic                              Sdram_Init_Done
);

  if (INIT_REF_CNT < 1) begin : g_bad_init_ref_cnt
    $error("INIT_REF_CNT must be at least 1");
  end
  if (CMD_GAP < 2) begin : g_bad_cmd_gap
    $error("CMD_GAP must be at least 2");
  end
  if (MAX_REF_DEBT < 2) begin : g_bad_max_ref_debt
    $error("MAX_REF_DEBT must be at least 2");
  end
  if (REF_PER < 2) begin : g_bad_ref_per
    $error("REF_PER must be at least 2");
  end

  localparam int T_PRE = INIT_PER + CMD_GAP;
  localparam int T_LMR = INIT_PER + (INIT_REF_CNT + 2) * CMD_GAP;
  localparam int TW    = $clog2(INIT_PER + (INIT_REF_CNT + 3) * CMD_GAP);
  localparam int KW    = $clog2(INIT_REF_CNT + 1);

  init_state_e      state_q, state_d;
  logic [TW-1:0]    t_q, t_d;
  logic [KW-1:0]    k_q, k_d;
  logic [TW-1:0]    t_ref;
  logic             init_restart;
  logic [ASIZE-1:0] saddr_q;

  // cycle of the next auto-refresh, k refreshes already issued
  assign t_ref = TW'(T_PRE + CMD_GAP) + TW'(CMD_GAP) * TW'(k_q);

  always_comb begin
    state_d      = state_q;
    t_d          = t_q + 1'b1;
    k_d          = k_q;
    PRECHARGE    = 1'b0;
    REFRESH      = 1'b0;
    LOAD_MODE    = 1'b0;
    INIT_REQ     = 1'b0;
    init_restart = 1'b0;
    case (state_q)
      ST_WAIT: begin
        INIT_REQ = (t_q < TW'(INIT_PER));
        if (t_q == TW'(T_PRE - 1)) state_d = ST_PRE;
      end
      ST_PRE: begin
        PRECHARGE = (t_q == TW'(T_PRE));
        if (t_q == TW'(T_PRE + CMD_GAP - 1)) state_d = ST_REF;
      end
      ST_REF: begin
        if (t_q == t_ref) begin
          REFRESH = 1'b1;
          k_d     = k_q + 1'b1;
        end
        if (t_q == TW'(T_LMR - 1)) state_d = ST_LMR;
      end
      ST_LMR: begin
        LOAD_MODE = 1'b1;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        t_d = t_q;
        if (INIT_START) begin
          state_d      = ST_WAIT;
          t_d          = '0;
          k_d          = '0;
          init_restart = 1'b1;
        end
      end
      default: begin
        state_d = ST_WAIT;
        t_d     = '0;
        k_d     = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_WAIT;
      t_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      k_q     <= k_d;
    end
  end

  assign Sdram_Init_Done = (state_q == ST_DONE);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      saddr_q     <= '0;
      bus.NOP     <= 1'b0;
      bus.READA   <= 1'b0;
      bus.WRITEA  <= 1'b0;
      bus.CMD_ACK <= 1'b0;
    end else begin
      saddr_q     <= bus.ADDR;
      bus.NOP     <= (bus.CMD == CMD_NOP);
      bus.READA   <= (bus.CMD == CMD_READA) && Sdram_Init_Done;
      bus.WRITEA  <= (bus.CMD == CMD_WRITEA) && Sdram_Init_Done;
      bus.CMD_ACK <= bus.CM_ACK & ~bus.CMD_ACK;
    end
  end

  assign bus.SADDR = saddr_q;

  sdram_refresh_scheduler #(
    .REF_PER      (REF_PER),
    .MAX_REF_DEBT (MAX_REF_DEBT)
  ) u_sched (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .enable     (Sdram_Init_Done),
    .clear      (init_restart),
    .REF_ACK    (REF_ACK),
    .REF_DEBT   (REF_DEBT),
    .REF_REQ    (REF_REQ),
    .REF_URGENT (REF_URGENT)
  );

endmodule

// File: tb/tb_sdram_init_refresh_ctrl.sv
// Directed bench for the SDRAM init/refresh controller with small timing parameters.
module tb_sdram_init_refresh_ctrl;

  localparam int ASIZE = 8;

  logic       CLK;
  logic       RESET_N;
  logic       REF_ACK;
  logic       INIT_START;
  logic       PRECHARGE;
  logic       REFRESH;
  logic       LOAD_MODE;
  logic       INIT_REQ;
  logic       REF_REQ;
  logic       REF_URGENT;
  logic [2:0] REF_DEBT;
  logic       done;

  int n_chk = 0;
  int n_err = 0;
  int tc    = 0;

  sdram_init_refresh_ctrl_if #(.ASIZE(ASIZE)) bus ();

  sdram_init_refresh_ctrl #(
    .ASIZE        (ASIZE),
    .INIT_PER     (100),
    .REF_PER      (50),
    .INIT_REF_CNT (2),
    .CMD_GAP      (4),
    .MAX_REF_DEBT (4)
  ) dut (
    .CLK             (CLK),
    .RESET_N         (RESET_N),
    .bus             (bus),
    .REF_ACK         (REF_ACK),
    .INIT_START      (INIT_START),
    .PRECHARGE       (PRECHARGE),
    .REFRESH         (REFRESH),
    .LOAD_MODE       (LOAD_MODE),
    .INIT_REQ        (INIT_REQ),
    .REF_REQ         (REF_REQ),
    .REF_URGENT      (REF_URGENT),
    .REF_DEBT        (REF_DEBT),
    .Sdram_Init_Done (done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s t=%0d: observed=%0h expected=%0h", tag, tc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    tc++;
  endtask

  // debt with no acknowledges since done at t=117: expiries at 166, 216, ...
  function automatic int exp_debt(input int t);
    int d;
    if (t < 167) return 0;
    d = (t - 167) / 50 + 1;
    return (d > 4) ? 4 : d;
  endfunction

  task automatic chk_cycle();
    int d;
    d = exp_debt(tc);
    chk("init_req",   32'(INIT_REQ),   32'(tc < 100));
    chk("precharge",  32'(PRECHARGE),  32'(tc == 104));
    chk("refresh",    32'(REFRESH),    32'(tc == 108 || tc == 112));
    chk("load_mode",  32'(LOAD_MODE),  32'(tc == 116));
    chk("init_done",  32'(done),       32'(tc >= 117));
    chk("ref_debt",   32'(REF_DEBT),   32'(d));
    chk("ref_req",    32'(REF_REQ),    32'(d != 0));
    chk("ref_urgent", 32'(REF_URGENT), 32'(d >= 3));
  endtask

  task automatic cyc();
    chk_cycle();
    step();
  endtask

  task automatic track(input int t_end);
    while (tc < t_end) cyc();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_flags"}, 32'({bus.NOP, bus.READA, bus.WRITEA, bus.CMD_ACK, PRECHARGE, REFRESH,
                             LOAD_MODE, INIT_REQ, REF_REQ, REF_URGENT, done}), 32'(11'b00000001000));
    chk({tag, "_saddr"}, 32'(bus.SADDR), 32'(0));
    chk({tag, "_debt"},  32'(REF_DEBT),  32'(0));
  endtask

  task automatic release_reset();
    @(negedge CLK);
    RESET_N = 1'b1;
    tc = 0;
  endtask

  initial begin
    RESET_N    = 1'b0;
    REF_ACK    = 1'b0;
    INIT_START = 1'b0;
    bus.CMD    = 2'b00;
    bus.ADDR   = '0;
    bus.CM_ACK = 1'b0;

    repeat (3) @(posedge CLK);
    #1;
    chk_reset("por");
    release_reset();

    // command during init: no read, and 01 is not a NOP
    track(50);
    bus.CMD  = 2'b01;
    bus.ADDR = 8'hA5;
    cyc();
    chk("init_reada", 32'({bus.NOP, bus.READA, bus.WRITEA}), 32'(3'b000));
    chk("saddr",      32'(bus.SADDR), 32'(8'hA5));
    bus.CMD  = 2'b00;
    bus.ADDR = 8'h3C;
    cyc();
    chk("saddr2",     32'(bus.SADDR), 32'(8'h3C));

    // acknowledge before init completes has no effect
    track(60);
    REF_ACK = 1'b1;
    cyc();
    REF_ACK = 1'b0;

    track(130);
    bus.CMD = 2'b01;
    cyc();
    chk("done_reada",  32'({bus.NOP, bus.READA, bus.WRITEA}), 32'(3'b010));
    bus.CMD = 2'b11;
    cyc();
    chk("rsvd_cmd",    32'({bus.NOP, bus.READA, bus.WRITEA}), 32'(3'b000));
    bus.CMD = 2'b10;
    cyc();
    chk("done_writea", 32'({bus.NOP, bus.READA, bus.WRITEA}), 32'(3'b001));
    bus.CMD = 2'b00;
    cyc();
    chk("done_nop",    32'({bus.NOP, bus.READA, bus.WRITEA}), 32'(3'b100));

    // CM_ACK held for cycles 140..144
    track(140);
    bus.CM_ACK = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (i == 4) bus.CM_ACK = 1'b0;
      chk("cmd_ack", 32'(bus.CMD_ACK), 32'((i % 2) == 0));
    end
    cyc();
    chk("cmd_ack_end", 32'(bus.CMD_ACK), 32'(0));

    // debt grows every 50 cycles and saturates at 4
    track(370);
    chk("sat_debt", 32'(REF_DEBT), 32'(4));

    REF_ACK = 1'b1;
    step();
    chk("ack_dec3",  32'({REF_DEBT, REF_REQ, REF_URGENT}), 32'({3'd3, 1'b1, 1'b1}));
    step();
    chk("ack_dec2",  32'({REF_DEBT, REF_REQ, REF_URGENT}), 32'({3'd2, 1'b1, 1'b0}));
    REF_ACK = 1'b0;
    while (tc < 416) step();
    chk("pre_expiry", 32'(REF_DEBT), 32'(2));
    REF_ACK = 1'b1;
    step();
    chk("ack_expiry", 32'(REF_DEBT), 32'(2));
    step();
    chk("ack_dec1",  32'(REF_DEBT), 32'(1));
    step();
    chk("ack_dec0",  32'({REF_DEBT, REF_REQ}), 32'({3'd0, 1'b0}));
    step();
    chk("ack_floor", 32'({REF_DEBT, REF_REQ}), 32'({3'd0, 1'b0}));
    REF_ACK = 1'b0;

    // soft re-init from DONE, then re-run with an ignored INIT_START in WAIT
    INIT_START = 1'b1;
    step();
    INIT_START = 1'b0;
    tc = 0;
    track(50);
    INIT_START = 1'b1;
    cyc();
    INIT_START = 1'b0;

    // reset mid-sequence during the refresh phase
    track(110);
    RESET_N = 1'b0;
    #2;
    chk_reset("mid_rst");
    repeat (2) @(posedge CLK);
    #1;
    chk_reset("mid_rst_hold");
    release_reset();

    track(200);
    INIT_START = 1'b1;
    cyc();
    INIT_START = 1'b0;
    tc = 0;
    track(130);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
